// File: rtl/decode_format_mux_if.sv
// Bundle between the parallel format decoders, the merge stage and the
// register-read/issue stage. Per-channel multi-bit fields are packed with
// channel 0 in the MSBs; one-bit-per-channel vectors use bit k for channel k.
interface decode_format_mux_if #(
  parameter int NUM_FMT       = 6,
  parameter int FMT_WIDTH     = 5,
  parameter int OPCODE_WIDTH  = 6,
  parameter int XOP_WIDTH     = 10,
  parameter int REG_WIDTH     = 5,
  parameter int ADDR_WIDTH    = 64,
  parameter int IMM_RAW_WIDTH = 16,
  parameter int ERR_CNT_WIDTH = 8
);
  // upstream side
  logic                                 valid_i;
  logic                                 ready_o;
  logic [ADDR_WIDTH-1:0]                instructionAddress_i;
  logic [OPCODE_WIDTH-1:0]              opcode_i;
  logic [NUM_FMT-1:0]                   fmtEnable_i;
  logic [NUM_FMT*3*REG_WIDTH-1:0]       fmtRegs_i;
  logic [NUM_FMT*3-1:0]                 fmtRegEnables_i;
  logic [NUM_FMT-1:0]                   fmtReg2ValOrZero_i;
  logic [NUM_FMT-1:0]                   fmtReg3IsImm_i;
  logic [NUM_FMT*IMM_RAW_WIDTH-1:0]     fmtImm_i;
  logic [NUM_FMT*8-1:0]                 fmtImmCtrl_i;
  logic [NUM_FMT*4-1:0]                 fmtBits_i;
  logic [NUM_FMT*(XOP_WIDTH+1)-1:0]     fmtXop_i;
  // downstream side
  logic                                 valid_o;
  logic                                 ready_i;
  logic [ADDR_WIDTH-1:0]                instructionAddress_o;
  logic [OPCODE_WIDTH-1:0]              opcode_o;
  logic [FMT_WIDTH-1:0]                 format_o;
  logic [REG_WIDTH-1:0]                 reg1_o;
  logic [REG_WIDTH-1:0]                 reg2_o;
  logic [REG_WIDTH-1:0]                 reg3_o;
  logic [2:0]                           regEnables_o;
  logic                                 reg2ValOrZero_o;
  logic                                 reg3IsImm_o;
  logic [63:0]                          imm_o;
  logic                                 immEnable_o;
  logic                                 bit1_o;
  logic                                 bit2_o;
  logic [1:0]                           bitEnables_o;
  logic [XOP_WIDTH-1:0]                 xOpcode_o;
  logic                                 xOpcodeEnable_o;
  logic                                 illegal_o;
  logic [ERR_CNT_WIDTH-1:0]             multiHitCount_o;

  modport slave (
    input  valid_i, instructionAddress_i, opcode_i, fmtEnable_i, fmtRegs_i,
           fmtRegEnables_i, fmtReg2ValOrZero_i, fmtReg3IsImm_i, fmtImm_i,
           fmtImmCtrl_i, fmtBits_i, fmtXop_i, ready_i,
    output ready_o, valid_o, instructionAddress_o, opcode_o, format_o,
           reg1_o, reg2_o, reg3_o, regEnables_o, reg2ValOrZero_o, reg3IsImm_o,
           imm_o, immEnable_o, bit1_o, bit2_o, bitEnables_o, xOpcode_o,
           xOpcodeEnable_o, illegal_o, multiHitCount_o
  );

  modport master (
    output valid_i, instructionAddress_i, opcode_i, fmtEnable_i, fmtRegs_i,
           fmtRegEnables_i, fmtReg2ValOrZero_i, fmtReg3IsImm_i, fmtImm_i,
           fmtImmCtrl_i, fmtBits_i, fmtXop_i, ready_i,
    input  ready_o, valid_o, instructionAddress_o, opcode_o, format_o,
           reg1_o, reg2_o, reg3_o, regEnables_o, reg2ValOrZero_o, reg3IsImm_o,
           imm_o, immEnable_o, bit1_o, bit2_o, bitEnables_o, xOpcode_o,
           xOpcodeEnable_o, illegal_o, multiHitCount_o
  );
endinterface

// File: rtl/decode_format_mux.sv
// Second decode stage: picks the lowest-index hitting format decoder, forms
// the 64-bit immediate and queues the result in a 2-entry skid buffer.
// ready_o depends only on the registered fill level, never on ready_i.
module decode_format_mux #(
  parameter int NUM_FMT       = 6,
  parameter int FMT_WIDTH     = 5,
  parameter int OPCODE_WIDTH  = 6,
  parameter int XOP_WIDTH     = 10,
  parameter int REG_WIDTH     = 5,
  parameter int ADDR_WIDTH    = 64,
  parameter int IMM_RAW_WIDTH = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                 clock_i,
  input  logic                 resetn_i,
  input  logic                 flush_i,
  decode_format_mux_if.slave   bus
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [FMT_WIDTH-1:0]    fmt;
    logic [REG_WIDTH-1:0]    reg1;
    logic [REG_WIDTH-1:0]    reg2;
    logic [REG_WIDTH-1:0]    reg3;
    logic [2:0]              reg_en;
    logic                    r2z;
    logic                    r3imm;
    logic [63:0]             imm;
    logic                    imm_en;
    logic                    bit1;
    logic                    bit2;
    logic [1:0]              bit_en;
    logic [XOP_WIDTH-1:0]    xop;
    logic                    xop_en;
    logic                    illegal;
  } entry_t;

  // Extend the raw field (sign or zero) to 64 bits, then shift left and truncate.
  function automatic logic [63:0] form_imm(input logic [IMM_RAW_WIDTH-1:0] raw,
                                           input logic sgn, input logic [5:0] sh);
    logic signed [63:0] ext;
    ext = {{(64-IMM_RAW_WIDTH){sgn & raw[IMM_RAW_WIDTH-1]}}, raw};
    return ext <<< sh;
  endfunction

  entry_t                   mem_q [2];
  entry_t                   mem_d [2];
  logic [1:0]               count_q, count_d;
  logic [ERR_CNT_WIDTH-1:0] mhc_q, mhc_d;
  entry_t                   new_e;
  logic                     found;
  logic [7:0]               imm_ctrl;
  logic                     multi_hit;
  logic                     ready, valid, push, pop;

  assign ready     = (count_q != 2'd2);
  assign valid     = (count_q != 2'd0);
  assign push      = bus.valid_i && ready && !flush_i;
  assign pop       = valid && bus.ready_i;
  assign multi_hit = |(bus.fmtEnable_i & (bus.fmtEnable_i - NUM_FMT'(1)));

  // Priority select of the lowest-index hitting channel into a buffer entry.
  always_comb begin
    new_e        = '0;
    new_e.addr   = bus.instructionAddress_i;
    new_e.opcode = bus.opcode_i;
    found        = 1'b0;
    imm_ctrl     = '0;
    for (int k = 0; k < NUM_FMT; k++) begin
      if (bus.fmtEnable_i[k] && !found) begin
        found        = 1'b1;
        new_e.fmt    = FMT_WIDTH'(k + 1);
        {new_e.reg1, new_e.reg2, new_e.reg3} =
          bus.fmtRegs_i[(NUM_FMT-1-k)*3*REG_WIDTH +: 3*REG_WIDTH];
        new_e.reg_en = bus.fmtRegEnables_i[(NUM_FMT-1-k)*3 +: 3];
        new_e.r2z    = bus.fmtReg2ValOrZero_i[k];
        new_e.r3imm  = bus.fmtReg3IsImm_i[k];
        imm_ctrl     = bus.fmtImmCtrl_i[(NUM_FMT-1-k)*8 +: 8];
        new_e.imm_en = imm_ctrl[7];
        new_e.imm    = imm_ctrl[7] ?
          form_imm(bus.fmtImm_i[(NUM_FMT-1-k)*IMM_RAW_WIDTH +: IMM_RAW_WIDTH],
                   imm_ctrl[6], imm_ctrl[5:0]) : 64'd0;
        {new_e.bit1, new_e.bit2, new_e.bit_en} = bus.fmtBits_i[(NUM_FMT-1-k)*4 +: 4];
        {new_e.xop_en, new_e.xop} =
          bus.fmtXop_i[(NUM_FMT-1-k)*(XOP_WIDTH+1) +: XOP_WIDTH+1];
      end
    end
    new_e.illegal = !found;
  end

  // Buffer next state: pop shifts the tail to the head, push lands behind it.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    mhc_d   = mhc_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        mem_d[0] = mem_q[1];
        count_d  = count_q - 2'd1;
      end
      if (push) begin
        mem_d[count_d[0]] = new_e;
        count_d           = count_d + 2'd1;
      end
    end
    if (push && multi_hit && (mhc_q != '1)) mhc_d = mhc_q + ERR_CNT_WIDTH'(1);
  end

  // State registers; everything clears on reset so outputs read zero.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      mem_q   <= '{default: '0};
      count_q <= 2'd0;
      mhc_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      mhc_q   <= mhc_d;
    end
  end

  assign bus.ready_o              = ready;
  assign bus.valid_o              = valid;
  assign bus.instructionAddress_o = mem_q[0].addr;
  assign bus.opcode_o             = mem_q[0].opcode;
  assign bus.format_o             = mem_q[0].fmt;
  assign bus.reg1_o               = mem_q[0].reg1;
  assign bus.reg2_o               = mem_q[0].reg2;
  assign bus.reg3_o               = mem_q[0].reg3;
  assign bus.regEnables_o         = mem_q[0].reg_en;
  assign bus.reg2ValOrZero_o      = mem_q[0].r2z;
  assign bus.reg3IsImm_o          = mem_q[0].r3imm;
  assign bus.imm_o                = mem_q[0].imm;
  assign bus.immEnable_o          = mem_q[0].imm_en;
  assign bus.bit1_o               = mem_q[0].bit1;
  assign bus.bit2_o               = mem_q[0].bit2;
  assign bus.bitEnables_o         = mem_q[0].bit_en;
  assign bus.xOpcode_o            = mem_q[0].xop;
  assign bus.xOpcodeEnable_o      = mem_q[0].xop_en;
  assign bus.illegal_o            = mem_q[0].illegal;
  assign bus.multiHitCount_o      = mhc_q;

endmodule

// File: tb/tb_decode_format_mux.sv
// Directed bench for decode_format_mux: selection, immediate forming,
// multi-hit counting, stall/skid behaviour, flush and asynchronous reset.
module tb_decode_format_mux;
  localparam int NF = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  decode_format_mux_if bus();

  decode_format_mux u_dut (
    .clock_i  (clk),
    .resetn_i (rst_n),
    .flush_i  (flush),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_chan(input int k, input logic [14:0] regs, input logic [2:0] ren,
                          input logic r2z, input logic r3i, input logic [15:0] imm,
                          input logic [7:0] ctl, input logic [3:0] bits, input logic [10:0] xop);
    bus.fmtRegs_i[(NF-1-k)*15 +: 15]     = regs;
    bus.fmtRegEnables_i[(NF-1-k)*3 +: 3] = ren;
    bus.fmtReg2ValOrZero_i[k]            = r2z;
    bus.fmtReg3IsImm_i[k]                = r3i;
    bus.fmtImm_i[(NF-1-k)*16 +: 16]      = imm;
    bus.fmtImmCtrl_i[(NF-1-k)*8 +: 8]    = ctl;
    bus.fmtBits_i[(NF-1-k)*4 +: 4]       = bits;
    bus.fmtXop_i[(NF-1-k)*11 +: 11]      = xop;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.instructionAddress_i = '0;
    bus.opcode_i = '0;
    bus.fmtEnable_i = '0;
    bus.fmtRegs_i = '0;
    bus.fmtRegEnables_i = '0;
    bus.fmtReg2ValOrZero_i = '0;
    bus.fmtReg3IsImm_i = '0;
    bus.fmtImm_i = '0;
    bus.fmtImmCtrl_i = '0;
    bus.fmtBits_i = '0;
    bus.fmtXop_i = '0;
    for (int k = 0; k < NF; k++)
      set_chan(k, {5'(k+1), 5'(k+2), 5'(k+3)}, 3'b111, 1'b1, 1'b1,
               16'(16'h0100 * (k+1)), 8'h80, 4'b1111, {1'b1, 10'(k+100)});
    // channel 0: D-form immediate 0x8000, signed, shift 16
    set_chan(0, {5'd1, 5'd2, 5'd3}, 3'b111, 1'b1, 1'b1, 16'h8000, 8'hD0, 4'b1111, {1'b1, 10'd100});
    // channel 2: unsigned immediate 0x9234 shifted by 4
    set_chan(2, {5'd3, 5'd4, 5'd5}, 3'b111, 1'b1, 1'b1, 16'h9234, 8'h84, 4'b1111, {1'b1, 10'd102});

    repeat (2) @(negedge clk);
    check_eq("rst_valid", bus.valid_o, 0);
    check_eq("rst_ready", bus.ready_o, 1);
    check_eq("rst_mhc", bus.multiHitCount_o, 0);
    check_eq("rst_imm", bus.imm_o, 0);
    check_eq("rst_fmt", bus.format_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single D-format hit on channel 0
    bus.fmtEnable_i = 6'b000001;
    bus.opcode_i = 6'd14;
    bus.instructionAddress_i = 64'h1000;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    check_eq("d_valid", bus.valid_o, 1);
    check_eq("d_fmt", bus.format_o, 1);
    check_eq("d_imm", bus.imm_o, 64'hFFFF_FFFF_8000_0000);
    check_eq("d_immen", bus.immEnable_o, 1);
    check_eq("d_reg1", bus.reg1_o, 1);
    check_eq("d_reg3", bus.reg3_o, 3);
    check_eq("d_opc", bus.opcode_o, 14);
    check_eq("d_addr", bus.instructionAddress_o, 64'h1000);
    check_eq("d_illegal", bus.illegal_o, 0);
    @(negedge clk);
    check_eq("d_drained", bus.valid_o, 0);

    // channels 2 and 4 together: channel 2 wins, multi-hit counted
    bus.fmtEnable_i = 6'b010100;
    bus.valid_i = 1'b1;
    @(negedge clk);
    check_eq("mh1_fmt", bus.format_o, 3);
    check_eq("mh1_imm", bus.imm_o, 64'h92340);
    check_eq("mh1_xop", bus.xOpcode_o, 102);
    @(negedge clk);
    check_eq("mh2_fmt", bus.format_o, 3);
    check_eq("mh2_cnt", bus.multiHitCount_o, 2);
    repeat (298) @(negedge clk);
    bus.valid_i = 1'b0;
    @(negedge clk);
    check_eq("mh_sat", bus.multiHitCount_o, 255);

    // no channel hit: illegal entry
    bus.fmtEnable_i = 6'b000000;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    check_eq("il_valid", bus.valid_o, 1);
    check_eq("il_illegal", bus.illegal_o, 1);
    check_eq("il_fmt", bus.format_o, 0);
    check_eq("il_immen", bus.immEnable_o, 0);
    check_eq("il_imm", bus.imm_o, 0);
    check_eq("il_regen", bus.regEnables_o, 0);
    check_eq("il_biten", bus.bitEnables_o, 0);
    check_eq("il_xopen", bus.xOpcodeEnable_o, 0);
    check_eq("il_mhc", bus.multiHitCount_o, 255);
    @(negedge clk);

    // downstream stall with three back-to-back offers
    bus.ready_i = 1'b0;
    bus.fmtEnable_i = 6'b000001;
    bus.opcode_i = 6'd1;
    bus.valid_i = 1'b1;
    @(negedge clk);
    check_eq("st_rdy_a", bus.ready_o, 1);
    check_eq("st_head_a", bus.opcode_o, 1);
    bus.fmtEnable_i = 6'b000010;
    bus.opcode_i = 6'd2;
    @(negedge clk);
    check_eq("st_rdy_b", bus.ready_o, 0);
    bus.fmtEnable_i = 6'b001000;
    bus.opcode_i = 6'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("st_hold_rdy", bus.ready_o, 0);
      check_eq("st_hold_opc", bus.opcode_o, 1);
      check_eq("st_hold_fmt", bus.format_o, 1);
      check_eq("st_hold_imm", bus.imm_o, 64'hFFFF_FFFF_8000_0000);
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    check_eq("st_out_b", bus.opcode_o, 2);
    check_eq("st_fmt_b", bus.format_o, 2);
    @(negedge clk);
    check_eq("st_out_c", bus.opcode_o, 3);
    check_eq("st_fmt_c", bus.format_o, 4);
    bus.valid_i = 1'b0;
    @(negedge clk);
    check_eq("st_empty", bus.valid_o, 0);

    // flush with a full buffer
    bus.ready_i = 1'b0;
    bus.fmtEnable_i = 6'b000001;
    bus.opcode_i = 6'd5;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.opcode_i = 6'd6;
    @(negedge clk);
    check_eq("fl_full", bus.ready_o, 0);
    bus.opcode_i = 6'd7;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.valid_i = 1'b0;
    check_eq("fl_valid", bus.valid_o, 0);
    check_eq("fl_ready", bus.ready_o, 1);
    bus.ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("fl_nodeliver", bus.valid_o, 0);

    // flush with one entry while the stage can accept
    bus.ready_i = 1'b0;
    bus.opcode_i = 6'd8;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.opcode_i = 6'd9;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.valid_i = 1'b0;
    check_eq("fl1_valid", bus.valid_o, 0);
    @(negedge clk);
    check_eq("fl1_noacc", bus.valid_o, 0);
    check_eq("fl1_mhc", bus.multiHitCount_o, 255);

    // asynchronous reset mid-stream
    bus.opcode_i = 6'd10;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    check_eq("ar_pre", bus.valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_valid", bus.valid_o, 0);
    check_eq("ar_ready", bus.ready_o, 1);
    check_eq("ar_mhc", bus.multiHitCount_o, 0);
    check_eq("ar_opc", bus.opcode_o, 0);
    check_eq("ar_imm", bus.imm_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ar_after", bus.valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
